multicycle_ctrl: RTL and testbench

Moore-style control FSM that sequences the multicycle RISC-V datapath whose state (pc, SrcA/SrcB, ALUResult, Result, MemWrite, Branch, MemtoReg, RegWrite) is shown on the LCD panel.
- Decodes the instruction-register fields and drives all mux selects and write enables, one state per cycle.
- Supports single-stepping from a board switch.
- Counts retired instructions and exports the current state for display.

---
 rtl/multicycle_ctrl.sv | 103 ++++++++++
 tb/tb_multicycle_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle RISC-V datapath with single-step and retire counter
module multicycle_ctrl #(
  parameter int NBITS_CNT = 8
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 step_en,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_control,
  output logic                 reg_write,
  output logic                 branch,
  output logic                 halted,
  output logic [3:0]           state_o,
  output logic [NBITS_CNT-1:0] instr_count
);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_HALT = 4'd15;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  logic [3:0]           r_state, w_next;
  logic [NBITS_CNT-1:0] r_count;
  logic                 w_retire, w_pc_update, w_ir, w_mem, w_reg;
  logic [1:0]           w_alu_op;
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else if (step_en) begin
      r_state <= w_next;
      r_count <= r_count + NBITS_CNT'(w_retire);
    end
  end
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE:  w_next = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                          opcode == OP_R   ? S_EXECR :
                          opcode == OP_I   ? S_EXECI :
                          opcode == OP_BEQ ? S_BEQ   :
                          opcode == OP_JAL ? S_JAL   : S_HALT;
      S_MEMADR:  w_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_FETCH;
    endcase
  end
  always_comb begin
    w_pc_update = 1'b0;
    w_ir        = 1'b0;
    w_mem       = 1'b0;
    w_reg       = 1'b0;
    w_alu_op    = 2'b00;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    branch      = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH:    begin w_ir = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; w_pc_update = 1'b1; end
      S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = 2'b01; w_reg = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; w_mem = 1'b1; end
      S_EXECR:    begin alu_src_a = 2'b10; w_alu_op = 2'b10; end
      S_EXECI:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; w_alu_op = 2'b10; end
      S_ALUWB:    w_reg = 1'b1;
      S_BEQ:      begin alu_src_a = 2'b10; w_alu_op = 2'b01; branch = 1'b1; end
      S_JAL:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; w_pc_update = 1'b1; end
      S_HALT:     halted = 1'b1;
      default:    ;
    endcase
  end
  // Subtract only for R-type with funct7[5]; I-type addi never subtracts
  assign alu_control = w_alu_op == 2'b00 ? 3'b000 :
                       w_alu_op == 2'b01 ? 3'b001 :
                       funct3 == 3'b000  ? ((opcode[5] & funct7b5) ? 3'b001 : 3'b000) :
                       funct3 == 3'b010  ? 3'b101 :
                       funct3 == 3'b110  ? 3'b011 :
                       funct3 == 3'b111  ? 3'b010 : 3'b000;
  assign w_retire    = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ);
  assign pc_write    = step_en & (w_pc_update | (branch & zero));
  assign ir_write    = step_en & w_ir;
  assign mem_write   = step_en & w_mem;
  assign reg_write   = step_en & w_reg;
  assign state_o     = r_state;
  assign instr_count = r_count;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed stepping of the control FSM through each instruction class
module tb_multicycle_ctrl;
  logic       clk_2 = 1'b0, reset = 1'b1, funct7b5 = 1'b0, zero = 1'b0, step_en = 1'b1;
  logic [6:0] opcode = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, branch, halted;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic [3:0] state_o;
  logic [7:0] instr_count;
  int         n_cmp = 0, n_bad = 0;

  multicycle_ctrl #(.NBITS_CNT(8)) dut (
    .clk_2(clk_2), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .step_en(step_en), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_write(reg_write), .branch(branch), .halted(halted), .state_o(state_o),
    .instr_count(instr_count)
  );

  always #5 clk_2 = ~clk_2;

  task automatic cyc();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    cyc();
    reset = 1'b0;
    #1;
    check("rst_state", state_o, 0);
    check("rst_count", instr_count, 0);
    check("fetch_ir", ir_write, 1);
    check("fetch_pc", pc_write, 1);
    check("fetch_srcb", alu_src_b, 2);
    check("fetch_res", result_src, 2);
    // lw
    cyc(); check("lw_s1", state_o, 1); check("dec_srca", alu_src_a, 1); check("dec_srcb", alu_src_b, 1);
    cyc(); check("lw_s2", state_o, 2); check("madr_srca", alu_src_a, 2);
    cyc(); check("lw_s3", state_o, 3); check("mrd_adr", adr_src, 1); check("mrd_rw", reg_write, 0);
    cyc(); check("lw_s4", state_o, 4); check("mwb_rw", reg_write, 1); check("mwb_res", result_src, 1);
    cyc(); check("lw_s0", state_o, 0); check("lw_cnt", instr_count, 1);
    // sw with a 3-cycle stall in MEMWRITE
    opcode = 7'b0100011;
    cyc(); check("sw_s1", state_o, 1);
    cyc(); check("sw_s2", state_o, 2);
    cyc(); check("sw_s5", state_o, 5); check("sw_mw", mem_write, 1); check("sw_adr", adr_src, 1);
    check("sw_rw", reg_write, 0);
    step_en = 1'b0;
    #1;
    check("stall_mw", mem_write, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); check("stall_state", state_o, 5); check("stall_mw2", mem_write, 0);
      check("stall_cnt", instr_count, 1); check("stall_adr", adr_src, 1);
    end
    step_en = 1'b1;
    #1;
    check("resume_mw", mem_write, 1);
    cyc(); check("sw_s0", state_o, 0); check("sw_mw0", mem_write, 0); check("sw_cnt", instr_count, 2);
    // R-type sub then and
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    cyc(); check("r_s1", state_o, 1);
    cyc(); check("r_s6", state_o, 6); check("r_sub", alu_control, 3'b001); check("r_srcb", alu_src_b, 0);
    funct3 = 3'b111;
    #1;
    check("r_and", alu_control, 3'b010);
    funct3 = 3'b010;
    #1;
    check("r_slt", alu_control, 3'b101);
    funct3 = 3'b110;
    #1;
    check("r_or", alu_control, 3'b011);
    cyc(); check("r_s8", state_o, 8); check("r_rw", reg_write, 1); check("r_res", result_src, 0);
    cyc(); check("r_s0", state_o, 0); check("r_cnt", instr_count, 3);
    // I-type addi with funct7b5 set must still add
    opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    cyc(); check("i_s1", state_o, 1);
    cyc(); check("i_s7", state_o, 7); check("i_add", alu_control, 3'b000); check("i_srcb", alu_src_b, 1);
    cyc(); check("i_s8", state_o, 8);
    cyc(); check("i_cnt", instr_count, 4);
    // beq taken / not taken
    opcode = 7'b1100011; zero = 1'b1;
    cyc(); check("b_s1", state_o, 1);
    cyc(); check("b_s9", state_o, 9); check("b_br", branch, 1); check("b_pcw1", pc_write, 1);
    check("b_sub", alu_control, 3'b001);
    zero = 1'b0;
    #1;
    check("b_pcw0", pc_write, 0);
    cyc(); check("b_s0", state_o, 0); check("b_cnt", instr_count, 5);
    // jal counts once, on leaving ALUWB
    opcode = 7'b1101111;
    cyc(); check("j_s1", state_o, 1);
    cyc(); check("j_s10", state_o, 10); check("j_pcw", pc_write, 1); check("j_srca", alu_src_a, 1);
    check("j_srcb", alu_src_b, 2);
    cyc(); check("j_s8", state_o, 8); check("j_rw", reg_write, 1); check("j_cnt_mid", instr_count, 5);
    cyc(); check("j_s0", state_o, 0); check("j_cnt", instr_count, 6);
    // illegal opcode halts
    opcode = 7'b1110011;
    cyc(); check("h_s1", state_o, 1);
    for (int i = 0; i < 11; i++) begin
      cyc(); check("h_state", state_o, 15); check("h_halted", halted, 1);
      check("h_en", {pc_write, ir_write, mem_write, reg_write}, 0);
    end
    check("h_cnt", instr_count, 6);
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    check("h_rst_state", state_o, 0); check("h_rst_cnt", instr_count, 0);
    // reset in the middle of a lw
    opcode = 7'b0000011;
    cyc(); cyc(); cyc(); check("m_s3", state_o, 3);
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    check("m_rst_state", state_o, 0); check("m_rst_cnt", instr_count, 0);
    check("m_rst_rw", reg_write, 0); check("m_rst_ir", ir_write, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
